// File: rtl/light_decoder.sv
// light_decoder
//
// Receive-side counterpart of the lights selector. It accepts 24-bit light
// words {R, G, B} over a valid/ready handshake and decodes each one to its
// 3-bit colour code {R_on, G_on, B_on}. It flags words that are not a legal
// colour. It also checks that successive cycling colours follow the
// selector's button cycle 1 -> 2 -> ... -> 6 -> 1.
//
// Output stage: a single register with pass-through ready, so latency is one
// cycle and the register can be reloaded in the same cycle it is popped.
//
// Optional feature macro: LIGHT_DEC_THRESHOLD_EN
//   defined   - each byte decodes by its MSB; invalid is tied low, so an
//               invalid word can never raise seq_err.
//   undefined - exact decode; each byte must be 8'h00 or 8'hFF, and any
//               other byte value marks the word invalid with colour 0.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low (0 = reset)
//   light_in      light word {R[23:16], G[15:8], B[7:0]}
//   light_valid   light_in is valid this cycle
//   light_ready   decoder can accept light_in
//   colour_out    decoded colour {R_on, G_on, B_on}
//   colour_valid  colour_out / invalid are valid
//   colour_ready  downstream accepts colour_out
//   invalid       current output word was not a legal colour
//   seq_err       one-cycle pulse: sequence violation on an accepted word
//   err_count     saturating count of seq_err pulses (ERR_CNT_W bits)

module light_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          light_in,
    input  logic                 light_valid,
    output logic                 light_ready,
    output logic [2:0]           colour_out,
    output logic                 colour_valid,
    input  logic                 colour_ready,
    output logic                 invalid,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {
        START,
        TRACK
    } seq_state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    seq_state_t           state_q, state_d;
    logic [2:0]           last_q, last_d;
    logic [2:0]           colour_q, colour_d;
    logic                 invalid_q, invalid_d;
    logic                 colour_valid_q, colour_valid_d;
    logic                 seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [2:0]           dec_colour;
    logic                 dec_invalid;
    logic [2:0]           next_colour;
    logic                 accept;

    // Ready is held low while reset is asserted so nothing is taken in
    // until the block is out of reset.
    assign light_ready = rst & (~colour_valid_q | colour_ready);
    assign accept      = light_valid & light_ready;

    // Byte-wise decode of the incoming light word. Colour bit i comes from
    // byte i, so B lands in bit 0 and R in bit 2.
    always_comb begin
        dec_colour  = 3'd0;
        dec_invalid = 1'b0;
`ifdef LIGHT_DEC_THRESHOLD_EN
        dec_colour  = {light_in[23], light_in[15], light_in[7]};
`else
        for (int i = 0; i < 3; i++) begin
            if (light_in[8*i +: 8] == 8'hFF) begin
                dec_colour[i] = 1'b1;
            end else if (light_in[8*i +: 8] != 8'h00) begin
                dec_invalid = 1'b1;
            end
        end
        if (dec_invalid) begin
            dec_colour = 3'd0;
        end
`endif
    end

    // Output register: load on accept, otherwise drop valid once popped.
    always_comb begin
        colour_d       = colour_q;
        invalid_d      = invalid_q;
        colour_valid_d = colour_valid_q;
        if (accept) begin
            colour_d       = dec_colour;
            invalid_d      = dec_invalid;
            colour_valid_d = 1'b1;
        end else if (colour_ready) begin
            colour_valid_d = 1'b0;
        end
    end

    // Sequence checker, evaluated only on accepted words. White (7) is
    // outside the button cycle and is ignored. An unexpected cycling colour
    // resynchronises the tracker to that colour, so one glitch reports once.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        seq_err_d   = 1'b0;
        next_colour = (last_q == 3'd6) ? 3'd1 : last_q + 3'd1;
        if (accept) begin
            if (dec_invalid) begin
                seq_err_d = 1'b1;
            end else if (dec_colour != 3'd7) begin
                unique case (state_q)
                    START: begin
                        if (dec_colour != 3'd0) begin
                            state_d = TRACK;
                            last_d  = dec_colour;
                        end
                    end
                    TRACK: begin
                        if (dec_colour == last_q) begin
                            last_d = last_q;
                        end else if (dec_colour == next_colour) begin
                            last_d = dec_colour;
                        end else if (dec_colour == 3'd0) begin
                            seq_err_d = 1'b1;
                            state_d   = START;
                            last_d    = 3'd0;
                        end else begin
                            seq_err_d = 1'b1;
                            last_d    = dec_colour;
                        end
                    end
                    default: begin
                        state_d = START;
                        last_d  = 3'd0;
                    end
                endcase
            end
        end
    end

    // The counter steps on the same edge that raises seq_err, so the count
    // already includes a word's error when that word appears on the output.
    always_comb begin
        err_count_d = err_count_q;
        if (seq_err_d && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
        end
    end

    // State registers; reset discards any in-flight word immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= START;
            last_q         <= 3'd0;
            colour_q       <= 3'd0;
            invalid_q      <= 1'b0;
            colour_valid_q <= 1'b0;
            seq_err_q      <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            colour_q       <= colour_d;
            invalid_q      <= invalid_d;
            colour_valid_q <= colour_valid_d;
            seq_err_q      <= seq_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign colour_out   = colour_q;
    assign colour_valid = colour_valid_q;
    assign invalid      = invalid_q;
    assign seq_err      = seq_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_light_decoder.sv
// tb_light_decoder
//
// Self-checking bench for light_decoder, built with ERR_CNT_W = 2 so that
// counter saturation is reachable. A reference model produces the expected
// colour / invalid / seq_err / err_count for each word when the word is
// accepted. The expectation is queued, then popped and compared when the
// decoder presents that word on its output.

module tb_light_decoder;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [23:0]   light_in = 24'd0;
    logic          light_valid = 1'b0;
    logic          light_ready;
    logic [2:0]    colour_out;
    logic          colour_valid;
    logic          colour_ready = 1'b1;
    logic          invalid;
    logic          seq_err;
    logic [CW-1:0] err_count;

    typedef struct packed {
        logic [2:0]    colour;
        logic          inv;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    bit            m_track = 1'b0;
    logic [2:0]    m_last  = 3'd0;
    logic [CW-1:0] m_cnt   = '0;

    bit acc_pend = 1'b0;

    light_decoder #(.ERR_CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .light_in     (light_in),
        .light_valid  (light_valid),
        .light_ready  (light_ready),
        .colour_out   (colour_out),
        .colour_valid (colour_valid),
        .colour_ready (colour_ready),
        .invalid      (invalid),
        .seq_err      (seq_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: decode a word, run the sequence rules, queue result.
    task automatic model_push(input logic [23:0] w);
        exp_t       e;
        logic [2:0] c;
        logic       inv;
        logic       err;
        logic [2:0] nxt;
        logic [7:0] b;
        c   = 3'd0;
        inv = 1'b0;
        err = 1'b0;
`ifdef LIGHT_DEC_THRESHOLD_EN
        c = {w[23], w[15], w[7]};
`else
        for (int k = 0; k < 3; k++) begin
            b = w[8*k +: 8];
            if (b == 8'hFF) c[k] = 1'b1;
            else if (b != 8'h00) inv = 1'b1;
        end
        if (inv) c = 3'd0;
`endif
        nxt = (m_last == 3'd6) ? 3'd1 : m_last + 3'd1;
        if (inv) begin
            err = 1'b1;
        end else if (c == 3'd7) begin
            err = 1'b0;
        end else if (!m_track) begin
            if (c != 3'd0) begin
                m_track = 1'b1;
                m_last  = c;
            end
        end else if (c == m_last) begin
            err = 1'b0;
        end else if (c == nxt) begin
            m_last = c;
        end else if (c == 3'd0) begin
            err     = 1'b1;
            m_track = 1'b0;
            m_last  = 3'd0;
        end else begin
            err    = 1'b1;
            m_last = c;
        end
        if (err && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        e.colour = c;
        e.inv    = inv;
        e.err    = err;
        e.cnt    = m_cnt;
        sb.push_back(e);
    endtask

    // Drive one word and wait (bounded) for it to be accepted.
    task automatic send(input logic [23:0] w);
        bit done;
        done = 1'b0;
        @(negedge clk);
        light_in    = w;
        light_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            if (light_ready) begin
                done = 1'b1;
                model_push(w);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout word=%06h not accepted within 20 cycles", w);
            light_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        light_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Record whether a word was accepted at this edge (pre-update values).
    always @(posedge clk) begin
        if (light_valid && light_ready && rst) acc_pend = 1'b1;
    end

    // Scoreboard: compare each newly loaded output word with its expectation;
    // between loads seq_err must stay low.
    always @(negedge clk) begin
        exp_t e;
        if (acc_pend) begin
            acc_pend = 1'b0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_empty output colour=%0d with no expectation queued", colour_out);
            end else begin
                e = sb.pop_front();
                if ({colour_valid, colour_out, invalid, seq_err, err_count} !==
                    {1'b1, e.colour, e.inv, e.err, e.cnt}) begin
                    errors++;
                    $display("[TB] FAIL output got vld=%0b col=%0d inv=%0b err=%0b cnt=%0d exp vld=1 col=%0d inv=%0b err=%0b cnt=%0d",
                             colour_valid, colour_out, invalid, seq_err, err_count,
                             e.colour, e.inv, e.err, e.cnt);
                end
            end
        end else if (rst) begin
            checks++;
            if (seq_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL seq_err_idle got %0b exp 0", seq_err);
            end
        end
    end

    task automatic test_reset();
        rst          = 1'b0;
        light_valid  = 1'b0;
        colour_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({colour_valid, colour_out, invalid, seq_err, err_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got vld=%0b col=%0d inv=%0b err=%0b cnt=%0d exp all 0",
                     colour_valid, colour_out, invalid, seq_err, err_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (light_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %0b exp 1", light_ready);
        end
    endtask

    task automatic test_stream();
        logic [23:0] words [8];
        words = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                  24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'h0000FF};
        colour_ready = 1'b1;
        foreach (words[i]) send(words[i]);
        idle(2);
        checks++;
        if (err_count !== 2'd0 || colour_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_end got cnt=%0d vld=%0b exp cnt=0 vld=0", err_count, colour_valid);
        end
    endtask

    task automatic test_backpressure();
        colour_ready = 1'b0;
        send(24'h00FF00);
        fork
            send(24'h00FFFF);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    #1;
                    checks++;
                    if ({colour_valid, colour_out, light_ready} !== {1'b1, 3'd2, 1'b0}) begin
                        errors++;
                        $display("[TB] FAIL hold cyc=%0d got vld=%0b col=%0d rdy=%0b exp vld=1 col=2 rdy=0",
                                 i, colour_valid, colour_out, light_ready);
                    end
                end
                colour_ready = 1'b1;
            end
        join
        idle(2);
    endtask

    task automatic test_white();
        send(24'hFFFFFF);
        send(24'hFF0000);
        idle(1);
    endtask

    task automatic test_seq_error();
        send(24'hFF00FF);
        send(24'hFFFF00);
        send(24'h0000FF);
        send(24'h00FF00);
        send(24'h00FF00);
        send(24'hFF0000);
        send(24'hFF00FF);
        idle(1);
        checks++;
        if (err_count !== 2'd1) begin
            errors++;
            $display("[TB] FAIL seq_err_count got %0d exp 1", err_count);
        end
    endtask

    task automatic test_invalid();
        send(24'h12FF00);
        send(24'hFFFF00);
        send(24'h000000);
        send(24'h00FFFF);
        idle(1);
        checks++;
        if (err_count !== m_cnt) begin
            errors++;
            $display("[TB] FAIL invalid_count got %0d exp %0d", err_count, m_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        colour_ready = 1'b0;
        send(24'h00FF00);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        acc_pend = 1'b0;
        m_track  = 1'b0;
        m_last   = 3'd0;
        m_cnt    = '0;
        checks++;
        if ({colour_valid, colour_out, invalid, seq_err, err_count} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got vld=%0b col=%0d inv=%0b err=%0b cnt=%0d exp all 0",
                     colour_valid, colour_out, invalid, seq_err, err_count);
        end
        light_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        colour_ready = 1'b1;
        #1;
        checks++;
        if ({light_ready, colour_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL post_reset got rdy=%0b vld=%0b exp rdy=1 vld=0", light_ready, colour_valid);
        end
    endtask

    task automatic test_saturation();
        send(24'h0000FF);
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 24'h00FFFF : 24'h0000FF);
        idle(3);
        checks++;
        if (err_count !== 2'd3) begin
            errors++;
            $display("[TB] FAIL saturate got %0d exp 3", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_white();
        test_seq_error();
        test_invalid();
        test_reset_midstream();
        test_saturation();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
